window_line_buffer_ctrl: RTL and testbench

// - Producer side of the 3x3 filter datapath. Accepts a raster pixel stream,

---
 rtl/window_line_buffer_ctrl_if.sv | 28 ++
 rtl/window_line_buffer_ctrl.sv | 134 +++++++++++++
 tb/tb_window_line_buffer_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_line_buffer_ctrl_if.sv
// Pixel-in / 3x3-window-out bundle between the stream
// source, the window line buffer and the filter.
interface window_line_buffer_ctrl_if;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic        pixel_in_ready;
    logic [71:0] data_out_box;
    logic        data_out_valid;
    logic        line_read_done;

    modport master (
        output pixel_in,
        output pixel_in_valid,
        input  pixel_in_ready,
        input  data_out_box,
        input  data_out_valid,
        input  line_read_done
    );

    modport slave (
        input  pixel_in,
        input  pixel_in_valid,
        output pixel_in_ready,
        output data_out_box,
        output data_out_valid,
        output line_read_done
    );
endinterface

// File: rtl/window_line_buffer_ctrl.sv
// Four rotating line buffers feeding 3x3 windows to the filter;
// one line is written while the other three are read.
module window_line_buffer_ctrl #(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    window_line_buffer_ctrl_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] LAST_WR = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] LAST_RD = CW'(IMG_WIDTH - 3);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    logic [PIX_W-1:0]   r_lb [4][IMG_WIDTH];
    logic [CW-1:0]      r_wr_col;
    logic [CW-1:0]      r_rd_col;
    logic [CW-1:0]      w_rd_col_nxt;
    logic [1:0]         r_wr_sel;
    logic [1:0]         r_rd_sel;
    logic [1:0]         w_rd_sel_nxt;
    logic [2:0]         r_full_lines;
    logic [2:0]         w_full_nxt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [9*PIX_W-1:0] r_box;
    logic [9*PIX_W-1:0] w_box;
    logic               r_valid;
    logic               r_done;
    logic               w_issue;
    logic               w_pass_end;
    logic               w_wr;
    logic               w_line_done;

    assign bus.pixel_in_ready = reset && (r_full_lines != 3'd4);
    assign w_wr        = bus.pixel_in_valid && bus.pixel_in_ready;
    assign w_line_done = w_wr && (r_wr_col == LAST_WR);

    assign bus.data_out_box   = r_box;
    assign bus.data_out_valid = r_valid;
    assign bus.line_read_done = r_done;

    // Row r of the window comes from buffer rd_sel+r, wrapping mod 4.
    always_comb begin
        w_box = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_box[(r*3+c)*PIX_W +: PIX_W] =
                    r_lb[r_rd_sel + 2'(r)][r_rd_col + CW'(c)];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_col_nxt = r_rd_col;
        w_rd_sel_nxt = r_rd_sel;
        w_issue      = 1'b0;
        w_pass_end   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_full_lines >= 3'd3) begin
                    w_state_nxt  = S_READ;
                    w_rd_col_nxt = '0;
                end
            end
            S_READ: begin
                w_issue = 1'b1;
                if (r_rd_col == LAST_RD) begin
                    w_pass_end   = 1'b1;
                    w_state_nxt  = S_IDLE;
                    w_rd_col_nxt = '0;
                    w_rd_sel_nxt = r_rd_sel + 2'd1;
                end else begin
                    w_rd_col_nxt = r_rd_col + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // A line completing in the same cycle a pass retires leaves the count unchanged.
    always_comb begin
        w_full_nxt = r_full_lines;
        if (w_line_done && !w_pass_end) begin
            w_full_nxt = r_full_lines + 3'd1;
        end else if (!w_line_done && w_pass_end) begin
            w_full_nxt = r_full_lines - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wr_col     <= '0;
            r_wr_sel     <= '0;
            r_rd_col     <= '0;
            r_rd_sel     <= '0;
            r_full_lines <= '0;
            r_box        <= '0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_col     <= w_rd_col_nxt;
            r_rd_sel     <= w_rd_sel_nxt;
            r_full_lines <= w_full_nxt;
            r_valid      <= w_issue;
            r_done       <= w_pass_end;
            if (w_issue) begin
                r_box <= w_box;
            end
            if (w_wr) begin
                if (w_line_done) begin
                    r_wr_col <= '0;
                    r_wr_sel <= r_wr_sel + 2'd1;
                end else begin
                    r_wr_col <= r_wr_col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_lb[r_wr_sel][r_wr_col] <= bus.pixel_in;
        end
    end
endmodule

// File: tb/tb_window_line_buffer_ctrl.sv
// Bench for window_line_buffer_ctrl: line-indexed image model plus
// hand-computed window literals.
module tb_window_line_buffer_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    window_line_buffer_ctrl_if bus ();

    window_line_buffer_ctrl #(
        .IMG_WIDTH(W),
        .PIX_W    (8)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    function automatic void chk(input string name, input logic [71:0] got,
                                input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Model: pixels indexed by line number since reset; pass p reads lines p..p+2.
    logic [7:0]  m_pix [64][W];
    int          m_wl, m_wc, m_full, m_pass, m_rc;
    bit          m_rd, m_live, m_lw, m_pe;
    logic [71:0] e_box;
    bit          e_valid, e_done;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_wl = 0; m_wc = 0; m_full = 0; m_pass = 0; m_rc = 0;
            m_rd = 0; e_box = '0; e_valid = 0; e_done = 0; m_live = 1;
        end else begin
            m_lw = 0; m_pe = 0; e_valid = 0; e_done = 0;
            if (m_rd) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e_box[(r*3+c)*8 +: 8] = m_pix[(m_pass+r)%64][m_rc+c];
                e_valid = 1;
                if (m_rc == W-3) begin
                    m_pe = 1; e_done = 1; m_rd = 0; m_pass++;
                end else begin
                    m_rc++;
                end
            end else if (m_full >= 3) begin
                m_rd = 1; m_rc = 0;
            end
            if (bus.pixel_in_valid && m_full != 4) begin
                m_pix[m_wl%64][m_wc] = bus.pixel_in;
                if (m_wc == W-1) begin
                    m_wc = 0; m_wl++; m_lw = 1;
                end else begin
                    m_wc++;
                end
            end
            m_full = m_full + int'(m_lw) - int'(m_pe);
        end
    end

    logic [71:0] obs_box [$];
    int          obs_t   [$];
    bit          obs_done[$];

    always @(negedge clk) begin
        #1;
        if (m_live) begin
            chk("valid", 72'(bus.data_out_valid), 72'(e_valid));
            chk("done",  72'(bus.line_read_done), 72'(e_done));
            chk("ready", 72'(bus.pixel_in_ready), 72'(rst_n && m_full != 4));
            chk("box",   bus.data_out_box, e_box);
            if (bus.data_out_valid) begin
                obs_box.push_back(bus.data_out_box);
                obs_t.push_back(cyc);
                obs_done.push_back(bus.line_read_done);
            end
        end
    end

    task automatic push(input int l, input int c);
        int g;
        g = 0;
        bus.pixel_in       = {4'(l), 4'(c)};
        bus.pixel_in_valid = 1'b1;
        while (!bus.pixel_in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("push_timeout", 72'(g < 100), 72'(1));
        @(negedge clk);
    endtask

    task automatic push_line(input int l, input bit gap);
        for (int c = 0; c < W; c++) begin
            push(l, c);
            if (gap && (c % 3 == 2)) begin
                bus.pixel_in_valid = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_obs(input int n);
        int g;
        g = 0;
        while (obs_box.size() < n && g < 300) begin
            @(negedge clk);
            #2;
            g++;
        end
        chk("wait_obs", 72'(obs_box.size() >= n), 72'(1));
    endtask

    function automatic int count_done();
        int n;
        n = 0;
        foreach (obs_done[i]) n += int'(obs_done[i]);
        return n;
    endfunction

    int acc;

    initial begin
        rst_n              = 1'b0;
        bus.pixel_in       = 8'hAA;
        bus.pixel_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_ready", 72'(bus.pixel_in_ready), 72'(0));
        chk("rst_valid", 72'(bus.data_out_valid), 72'(0));
        chk("rst_done",  72'(bus.line_read_done), 72'(0));
        chk("rst_box",   bus.data_out_box, 72'h0);
        rst_n              = 1'b1;
        bus.pixel_in_valid = 1'b0;
        @(negedge clk);

        for (int l = 0; l < 3; l++) push_line(l, 0);
        acc = cyc;
        bus.pixel_in_valid = 1'b0;
        wait_obs(6);
        if (obs_box.size() >= 6) begin
            chk("first_latency", 72'(obs_t[0]), 72'(acc + 2));
            chk("six_consec",    72'(obs_t[5]), 72'(obs_t[0] + 5));
            chk("first_box", obs_box[0], 72'h22_21_20_12_11_10_02_01_00);
            chk("last_box",  obs_box[5], 72'h27_26_25_17_16_15_07_06_05);
            chk("done_early", 72'(obs_done[4]), 72'(0));
            chk("done_last",  72'(obs_done[5]), 72'(1));
        end

        for (int l = 3; l < 5; l++) push_line(l, 0);
        bus.pixel_in_valid = 1'b0;
        wait_obs(18);
        if (obs_box.size() >= 18) begin
            chk("pass2_first", obs_box[6],  72'h32_31_30_22_21_20_12_11_10);
            chk("pass3_wrap",  obs_box[12], 72'h42_41_40_32_31_30_22_21_20);
            chk("passes_5l",   72'(count_done()), 72'(3));
        end

        for (int l = 5; l < 10; l++) push_line(l, 0);
        bus.pixel_in_valid = 1'b0;
        wait_obs(48);
        if (obs_box.size() >= 48) begin
            chk("stream_last", obs_box[47], 72'h97_96_95_87_86_85_77_76_75);
            chk("passes_10l",  72'(count_done()), 72'(8));
        end

        for (int l = 10; l < 13; l++) push_line(l, 1);
        bus.pixel_in_valid = 1'b0;
        wait_obs(66);
        if (obs_box.size() >= 66) begin
            chk("gap_first", obs_box[48], 72'hA2_A1_A0_92_91_90_82_81_80);
            chk("gap_last",  obs_box[65], 72'hC7_C6_C5_B7_B6_B5_A7_A6_A5);
        end

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_box.delete(); obs_t.delete(); obs_done.delete();
        for (int l = 0; l < 3; l++) push_line(l, 0);
        bus.pixel_in_valid = 1'b0;
        wait_obs(3);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        chk("midrst_valid", 72'(bus.data_out_valid), 72'(0));
        chk("midrst_done",  72'(bus.line_read_done), 72'(0));
        chk("midrst_count", 72'(obs_box.size()), 72'(3));
        rst_n = 1'b1;
        @(negedge clk);
        for (int l = 0; l < 3; l++) push_line(l, 0);
        bus.pixel_in_valid = 1'b0;
        wait_obs(4);
        if (obs_box.size() >= 4) begin
            chk("refill_box", obs_box[3], 72'h22_21_20_12_11_10_02_01_00);
        end
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
